// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave endpoint: response codes,
// FSM state encoding and the read pattern returned on a backend timeout.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_WR_RESP  = 2'd2,
    ST_RD_RESP  = 2'd3
  } state_e;

  // Map a backend completion to the AXI response code.
  function automatic logic [1:0] mem_resp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_if_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master/slave views.
interface axi4_lite_slave_if_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slave_if_watchdog.sv
// Backend watchdog: reloads to LIMIT while loaded, counts down while
// enabled, and flags expiry once the count reaches zero.
module axi_slave_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // Down-counter that saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LIMIT);
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);
endmodule

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite slave endpoint bridging to a single-beat native memory port.
// One transaction outstanding; alternating read/write arbitration.
// Optional backend watchdog enabled by defining AXI_SLAVE_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | collecting AW/W, arbitrating against AR, decoding
// ST_MEM_WAIT | backend request issued, waiting for mem_ready
// ST_WR_RESP  | BVALID asserted, waiting for BREADY
// ST_RD_RESP  | RVALID asserted, waiting for RREADY
module axi4_lite_slave_if
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = 'h0001_0000,
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4_lite_slave_if_if.slave   axi,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  mem_req,
  output logic                  mem_wr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  input  logic                  mem_error
);

  state_e                state;
  logic                  aw_held, w_held, last_was_write, is_write;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic                  in_idle, ar_fire, aw_fire, w_fire, wr_grant;
  logic                  wr_in_win, rd_in_win, timed_out;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;

  assign in_idle = (state == ST_IDLE);

  // Read is offered only when no write has been partially collected and
  // either no write is being presented or it is the read's turn.
  assign axi.arready = in_idle && !aw_held && !w_held &&
                       (!(axi.awvalid || axi.wvalid) || last_was_write);
  assign ar_fire     = axi.arready && axi.arvalid;
  assign axi.awready = in_idle && !aw_held && !ar_fire;
  assign axi.wready  = in_idle && !w_held && !ar_fire;
  assign aw_fire     = axi.awready && axi.awvalid;
  assign w_fire      = axi.wready && axi.wvalid;

  // The write is granted in the cycle its last half arrives, using the
  // live bus value for whichever half is not yet held.
  assign wr_grant = in_idle && (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_addr  = aw_held ? awaddr_q : axi.awaddr;
  assign wr_data  = w_held  ? wdata_q  : axi.wdata;
  assign wr_strb  = w_held  ? wstrb_q  : axi.wstrb;

  // Unsigned offset compare also rejects addresses below BASE_ADDR.
  assign wr_off    = wr_addr - BASE_ADDR;
  assign rd_off    = axi.araddr - BASE_ADDR;
  assign wr_in_win = (wr_off < ADDR_SPAN);
  assign rd_in_win = (rd_off < ADDR_SPAN);

  logic unused_bits;
  assign unused_bits = ^{axi.awprot, axi.arprot, wr_off[1:0], rd_off[1:0]};

`ifdef AXI_SLAVE_TIMEOUT_EN
  logic wd_expire;

  axi_slave_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state != ST_MEM_WAIT),
    .count  (state == ST_MEM_WAIT),
    .expire (wd_expire)
  );

  assign timed_out = wd_expire;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  // Transaction FSM with registered AXI responses and backend request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      last_was_write <= 1'b0;
      is_write       <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      axi.bvalid     <= 1'b0;
      axi.bresp      <= RESP_OKAY;
      axi.rvalid     <= 1'b0;
      axi.rresp      <= RESP_OKAY;
      axi.rdata      <= '0;
      mem_req        <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
    end else begin
      mem_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (aw_fire) begin
            aw_held  <= 1'b1;
            awaddr_q <= axi.awaddr;
          end
          if (w_fire) begin
            w_held  <= 1'b1;
            wdata_q <= axi.wdata;
            wstrb_q <= axi.wstrb;
          end
          if (wr_grant) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            last_was_write <= 1'b1;
            is_write       <= 1'b1;
            if (wr_in_win) begin
              mem_req   <= 1'b1;
              mem_wr    <= 1'b1;
              mem_addr  <= {wr_off[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= wr_data;
              mem_wstrb <= wr_strb;
              state     <= ST_MEM_WAIT;
            end else begin
              axi.bvalid <= 1'b1;
              axi.bresp  <= RESP_DECERR;
              state      <= ST_WR_RESP;
            end
          end else if (ar_fire) begin
            last_was_write <= 1'b0;
            is_write       <= 1'b0;
            if (rd_in_win) begin
              mem_req   <= 1'b1;
              mem_wr    <= 1'b0;
              mem_addr  <= {rd_off[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= '0;
              mem_wstrb <= 4'hF;
              state     <= ST_MEM_WAIT;
            end else begin
              axi.rvalid <= 1'b1;
              axi.rresp  <= RESP_DECERR;
              axi.rdata  <= '0;
              state      <= ST_RD_RESP;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            if (is_write) begin
              axi.bvalid <= 1'b1;
              axi.bresp  <= mem_resp(mem_error);
              state      <= ST_WR_RESP;
            end else begin
              axi.rvalid <= 1'b1;
              axi.rresp  <= mem_resp(mem_error);
              axi.rdata  <= mem_rdata;
              state      <= ST_RD_RESP;
            end
          end else if (timed_out) begin
            if (is_write) begin
              axi.bvalid <= 1'b1;
              axi.bresp  <= RESP_SLVERR;
              state      <= ST_WR_RESP;
            end else begin
              axi.rvalid <= 1'b1;
              axi.rresp  <= RESP_SLVERR;
              axi.rdata  <= TIMEOUT_RDATA;
              state      <= ST_RD_RESP;
            end
          end
        end
        ST_WR_RESP: begin
          if (axi.bready) begin
            axi.bvalid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_RD_RESP: begin
          if (axi.rready) begin
            axi.rvalid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_if.sv
// Directed bench for axi4_lite_slave_if: a vector table of single
// transactions plus hand sequences for W-before-AW, reset abandonment,
// arbitration alternation and (with AXI_SLAVE_TIMEOUT_EN) the watchdog.
`timescale 1ns/1ps
module tb_axi4_lite_slave_if;
  import axi4_lite_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_slave_if_if #(.ADDR_WIDTH(32)) bus ();

  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req, mem_wr, mem_ready, mem_error;

  axi4_lite_slave_if #(
    .ADDR_WIDTH     (32),
    .BASE_ADDR      (32'h0000_0000),
    .ADDR_SPAN      (32'h0001_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axi       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_error (mem_error)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Backend model: answers each request bk_wait cycles after the
  // request cycle, unless bk_silent.
  int          bk_wait = 0;
  logic        bk_err = 1'b0;
  logic [31:0] bk_rdata = '0;
  logic        bk_silent = 1'b0;

  int          req_cnt = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        cap_wr = 1'b0;
  logic        wr_log[$];

  always @(negedge clk) begin
    if (mem_req) begin
      req_cnt++;
      cap_addr  = mem_addr;
      cap_wdata = mem_wdata;
      cap_wstrb = mem_wstrb;
      cap_wr    = mem_wr;
      wr_log.push_back(mem_wr);
    end
  end

  initial begin
    mem_ready = 1'b0;
    mem_error = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !bk_silent) begin
        repeat (bk_wait) @(negedge clk);
        mem_ready = 1'b1;
        mem_error = bk_err;
        mem_rdata = bk_rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_error = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  task automatic clear_bus();
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_bus();
    repeat (2) @(negedge clk);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_resps", {bus.bresp, bus.rresp}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem_ctl", {mem_req, mem_wr, mem_wstrb}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Write with W presented w_lead cycles ahead of AW; checks response latency
  // counted from the cycle after the last address/data handshake.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead,
                          input int exp_lat, input logic [1:0] exp_resp);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int c = 0, lat;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.wvalid = 1'b1;
    bus.awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && c < 50) begin
      #1;
      aw_f = bus.awvalid && bus.awready;
      w_f  = bus.wvalid && bus.wready;
      if (w_done && !aw_done) begin
        chk("w_held_wready", bus.wready, 0);
        chk("w_held_no_req", mem_req, 0);
      end
      @(negedge clk);
      c++;
      if (aw_f) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_f)  begin w_done = 1;  bus.wvalid = 1'b0;  end
      if (c == w_lead && !aw_done) bus.awvalid = 1'b1;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("wr_handshake", {aw_done, w_done}, 2'b11);
    lat = 1;
    while (!bus.bvalid && lat < 60) begin @(negedge clk); lat++; end
    chk("wr_latency", lat, exp_lat);
    chk("bresp", bus.bresp, exp_resp);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk("b_done", bus.bvalid, 0);
  endtask

  // Read; RREADY is held low for `hold` cycles after RVALID to check stability.
  task automatic do_read(input logic [31:0] addr, input int hold, input int exp_lat,
                         input logic [1:0] exp_resp, input logic [31:0] exp_data);
    bit ar_done = 0, ar_f;
    int c = 0, lat;
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (!ar_done && c < 50) begin
      #1;
      ar_f = bus.arvalid && bus.arready;
      @(negedge clk);
      c++;
      if (ar_f) begin ar_done = 1; bus.arvalid = 1'b0; end
    end
    bus.arvalid = 1'b0;
    chk("rd_handshake", ar_done, 1);
    lat = 1;
    while (!bus.rvalid && lat < 60) begin @(negedge clk); lat++; end
    chk("rd_latency", lat, exp_lat);
    chk("rresp", bus.rresp, exp_resp);
    chk("rdata", bus.rdata, exp_data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rd_hold_rvalid", bus.rvalid, 1);
      chk("rd_hold_rdata", bus.rdata, exp_data);
      chk("rd_hold_rresp", bus.rresp, exp_resp);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    chk("r_done", bus.rvalid, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          bwait;
    bit          berr;
    logic [31:0] brdata;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          req;
    logic [31:0] maddr;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int req_before;
    bit aw_f, w_f, ar_f, b_f, r_f;
    int n_aw, n_w, n_ar, n_b, n_r;
    logic exp_order[3];

    //              wr addr           wdata          strb   wait err brdata         resp         rdata          req maddr          lat
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'b0011, 0, 1'b0, 32'h0,         RESP_OKAY,   32'h0,         1'b1, 32'h0000_0010, 2};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 3, 1'b0, 32'hCAFE_F00D, RESP_OKAY,   32'hCAFE_F00D, 1'b1, 32'h0000_0020, 5};
    vecs[2] = '{1'b0, 32'h0002_0000, 32'h0,         4'b0000, 0, 1'b0, 32'h5555_5555, RESP_DECERR, 32'h0,         1'b0, 32'h0,         1};
    vecs[3] = '{1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'b1111, 1, 1'b1, 32'h0,         RESP_SLVERR, 32'h0,         1'b1, 32'h0000_0044, 3};
    vecs[4] = '{1'b0, 32'h0000_0FFE, 32'h0,         4'b0000, 0, 1'b1, 32'h1234_5678, RESP_SLVERR, 32'h1234_5678, 1'b1, 32'h0000_0FFC, 2};
    vecs[5] = '{1'b1, 32'h0001_0000, 32'h1111_2222, 4'b1111, 0, 1'b0, 32'h0,         RESP_DECERR, 32'h0,         1'b0, 32'h0,         1};
    vecs[6] = '{1'b0, 32'h0000_FFFC, 32'h0,         4'b0000, 2, 1'b0, 32'h600D_CAFE, RESP_OKAY,   32'h600D_CAFE, 1'b1, 32'h0000_FFFC, 4};
    vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'h3333_4444, 4'b1000, 0, 1'b0, 32'h0,         RESP_DECERR, 32'h0,         1'b0, 32'h0,         1};

    clear_bus();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      bk_wait = vecs[i].bwait; bk_err = vecs[i].berr; bk_rdata = vecs[i].brdata;
      req_before = req_cnt;
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, vecs[i].lat, vecs[i].resp);
      else
        do_read(vecs[i].addr, 5, vecs[i].lat, vecs[i].resp, vecs[i].rdata);
      chk("mem_req_count", req_cnt - req_before, {31'd0, vecs[i].req});
      if (vecs[i].req) begin
        chk("mem_addr", cap_addr, vecs[i].maddr);
        chk("mem_wr", cap_wr, vecs[i].wr);
        chk("mem_wstrb", cap_wstrb, vecs[i].wr ? vecs[i].wstrb : 4'hF);
        if (vecs[i].wr) chk("mem_wdata", cap_wdata, vecs[i].wdata);
      end
    end

    // W three cycles ahead of AW: one request, OKAY.
    bk_wait = 0; bk_err = 1'b0;
    req_before = req_cnt;
    do_write(32'h0000_0030, 32'h8765_4321, 4'b1111, 3, 2, RESP_OKAY);
    chk("w_early_req_count", req_cnt - req_before, 1);
    chk("w_early_addr", cap_addr, 32'h0000_0030);
    chk("w_early_wdata", cap_wdata, 32'h8765_4321);

    // Reset mid-read abandons it; the late mem_ready lands in IDLE.
    bk_wait = 10; bk_rdata = 32'h9999_9999;
    bus.araddr = 32'h0000_0040; bus.arvalid = 1'b1;
    #1 chk("mid_arready", bus.arready, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abandon_rvalid", bus.rvalid, 0);
    end

    // Contention after reset: write, then read, then write.
    do_reset();
    bk_wait = 0; bk_err = 1'b0; bk_rdata = 32'h7777_0001;
    wr_log.delete();
    bus.awaddr = 32'h0000_0100; bus.wdata = 32'h0000_00AA; bus.wstrb = 4'hF;
    bus.araddr = 32'h0000_0200;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0;
    #1;
    chk("arb_first_arready", bus.arready, 0);
    chk("arb_first_awready", bus.awready, 1);
    for (int c = 0; c < 80 && (n_b < 2 || n_r < 1); c++) begin
      #1;
      aw_f = bus.awvalid && bus.awready;
      w_f  = bus.wvalid && bus.wready;
      ar_f = bus.arvalid && bus.arready;
      b_f  = bus.bvalid && bus.bready;
      r_f  = bus.rvalid && bus.rready;
      if (ar_f) chk("arb_ar_blocks_aw", {bus.awready, bus.wready}, 0);
      @(negedge clk);
      if (aw_f) begin n_aw++; if (n_aw == 2) bus.awvalid = 1'b0; end
      if (w_f)  begin n_w++;  if (n_w == 2)  bus.wvalid = 1'b0;  end
      if (ar_f) begin n_ar++; bus.arvalid = 1'b0; end
      if (b_f) n_b++;
      if (r_f) n_r++;
    end
    clear_bus();
    chk("arb_b_count", n_b, 2);
    chk("arb_r_count", n_r, 1);
    chk("arb_order_len", wr_log.size(), 3);
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
    for (int i = 0; i < 3 && i < wr_log.size(); i++)
      chk("arb_order", wr_log[i], exp_order[i]);

`ifdef AXI_SLAVE_TIMEOUT_EN
    // Silent backend: SLVERR with the timeout pattern at cycle 18.
    @(negedge clk);
    bk_silent = 1'b1;
    do_read(32'h0000_0050, 1, 18, RESP_SLVERR, TIMEOUT_RDATA);
    bk_silent = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
